// File: rtl/cpu_port_host_pkg.sv
// rtl/cpu_port_host_pkg.sv - shared INT FSM encodings and default queue depths
package cpu_port_host_pkg;

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_PULSE   = 2'd1;
   localparam logic [1:0] S_HOLDOFF = 2'd2;

   localparam int DEF_OUT_DEPTH = 8;
   localparam int DEF_IN_DEPTH  = 8;

endpackage

// File: rtl/cpu_port_host_sync_fifo.sv
// rtl/cpu_port_host_sync_fifo.sv - single-clock FIFO, power-of-2 depth
module cpu_port_host_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic [WIDTH-1:0]         head
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = 1;
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full  = (count == CNT_FULL);
   assign empty = (count == '0);
   assign head  = mem[rd_ptr];

   // A pop frees a slot in the same cycle, so a full FIFO can still take a push.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/cpu_port_host.sv
// rtl/cpu_port_host.sv - external-side partner of the CPU IN/OUT ports with interrupt pulse generator
module cpu_port_host
   import cpu_port_host_pkg::*;
#(
   parameter int OUT_DEPTH = DEF_OUT_DEPTH,
   parameter int IN_DEPTH  = DEF_IN_DEPTH,
   parameter int INT_PULSE = 2,
   parameter int INT_ON_RX = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] cpu_out_port,
   input  logic       cpu_out_we,
   input  logic       cpu_in_ack,
   input  logic       cpu_hlt,
   output logic [7:0] cpu_in_port,
   output logic       cpu_int,
   output logic [7:0] h_tx_data,
   output logic       h_tx_valid,
   input  logic       h_tx_ready,
   input  logic [7:0] h_rx_data,
   input  logic       h_rx_valid,
   output logic       h_rx_ready,
   input  logic       h_irq_req,
   output logic       in_avail,
   output logic       out_overflow,
   output logic       halted
);

   localparam logic [3:0] CNT_INIT = 4'(INT_PULSE - 1);
   localparam logic [$clog2(IN_DEPTH):0] IN_ONE = 1;

   logic                        out_full;
   logic                        out_empty;
   logic [$clog2(OUT_DEPTH):0]  out_count;
   logic                        tx_pop;
   logic                        in_full;
   logic                        in_empty;
   logic [$clog2(IN_DEPTH):0]   in_count;
   logic [7:0]                  in_head;
   logic                        in_push;
   logic                        in_pop;
   logic                        run_q;
   logic [7:0]                  in_last;
   logic                        irq_d;
   logic                        irq_rise;
   logic                        rx_new;
   logic                        trigger;
   logic [1:0]                  state;
   logic [3:0]                  cnt;
   logic                        pending;
   logic                        unused_out_count;

   assign unused_out_count = ^out_count;

   assign h_tx_valid = ~out_empty;
   assign tx_pop     = h_tx_valid & h_tx_ready;

   cpu_port_host_sync_fifo #(.WIDTH(8), .DEPTH(OUT_DEPTH)) u_out_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (cpu_out_we),
      .pop   (tx_pop),
      .din   (cpu_out_port),
      .full  (out_full),
      .empty (out_empty),
      .count (out_count),
      .head  (h_tx_data)
   );

   // run_q keeps h_rx_ready low while reset is held, even though the count reads empty.
   assign h_rx_ready = run_q & ~in_full;
   assign in_avail   = ~in_empty;
   assign in_push    = h_rx_valid & h_rx_ready;
   assign in_pop     = cpu_in_ack & in_avail;

   cpu_port_host_sync_fifo #(.WIDTH(8), .DEPTH(IN_DEPTH)) u_in_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (in_push),
      .pop   (in_pop),
      .din   (h_rx_data),
      .full  (in_full),
      .empty (in_empty),
      .count (in_count),
      .head  (in_head)
   );

   assign cpu_in_port = in_avail ? in_head : in_last;

   assign irq_rise = h_irq_req & ~irq_d;
   assign trigger  = irq_rise | rx_new;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         run_q        <= 1'b0;
         in_last      <= 8'h00;
         irq_d        <= 1'b0;
         rx_new       <= 1'b0;
         out_overflow <= 1'b0;
         halted       <= 1'b0;
      end else begin
         run_q  <= 1'b1;
         irq_d  <= h_irq_req;
         halted <= cpu_hlt;
         if (in_avail) begin
            in_last <= in_head;
         end
         // A fresh byte reaches the head either by landing in an empty queue or by popping onto a waiting one.
         rx_new <= (INT_ON_RX != 0) &&
                   ((in_push && in_empty) || (in_pop && (in_count > IN_ONE)));
         if (cpu_out_we && out_full && !tx_pop) begin
            out_overflow <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= S_IDLE;
         cnt     <= 4'd0;
         cpu_int <= 1'b0;
         pending <= 1'b0;
      end else if (cpu_hlt) begin
         state   <= S_IDLE;
         cnt     <= 4'd0;
         cpu_int <= 1'b0;
         pending <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (trigger || pending) begin
                  state   <= S_PULSE;
                  cnt     <= CNT_INIT;
                  cpu_int <= 1'b1;
                  pending <= 1'b0;
               end
            end
            S_PULSE: begin
               if (irq_rise) begin
                  pending <= 1'b1;
               end
               if (cnt == 4'd0) begin
                  state   <= S_HOLDOFF;
                  cpu_int <= 1'b0;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            S_HOLDOFF: begin
               if (trigger) begin
                  pending <= 1'b1;
               end
               if (cpu_in_ack || !in_avail) begin
                  state <= S_IDLE;
               end
            end
            default: begin
               state   <= S_IDLE;
               cpu_int <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_port_host.sv
// tb/tb_cpu_port_host.sv - directed self-checking bench for cpu_port_host
module tb_cpu_port_host;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] cpu_out_port;
   logic       cpu_out_we;
   logic       cpu_in_ack;
   logic       cpu_hlt;
   logic [7:0] cpu_in_port;
   logic       cpu_int;
   logic [7:0] h_tx_data;
   logic       h_tx_valid;
   logic       h_tx_ready;
   logic [7:0] h_rx_data;
   logic       h_rx_valid;
   logic       h_rx_ready;
   logic       h_irq_req;
   logic       in_avail;
   logic       out_overflow;
   logic       halted;

   int checks = 0;
   int errors = 0;
   int n_int;

   always #5 clk = ~clk;

   cpu_port_host dut (
      .clk          (clk),
      .rst          (rst),
      .cpu_out_port (cpu_out_port),
      .cpu_out_we   (cpu_out_we),
      .cpu_in_ack   (cpu_in_ack),
      .cpu_hlt      (cpu_hlt),
      .cpu_in_port  (cpu_in_port),
      .cpu_int      (cpu_int),
      .h_tx_data    (h_tx_data),
      .h_tx_valid   (h_tx_valid),
      .h_tx_ready   (h_tx_ready),
      .h_rx_data    (h_rx_data),
      .h_rx_valid   (h_rx_valid),
      .h_rx_ready   (h_rx_ready),
      .h_irq_req    (h_irq_req),
      .in_avail     (in_avail),
      .out_overflow (out_overflow),
      .halted       (halted)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic count_int(input int cycles, output int hi);
      hi = 0;
      for (int i = 0; i < cycles; i++) begin
         if (cpu_int) hi++;
         step();
      end
   endtask

   initial begin
      rst = 1'b0; cpu_out_port = 8'h00; cpu_out_we = 1'b0; cpu_in_ack = 1'b0;
      cpu_hlt = 1'b0; h_tx_ready = 1'b0; h_rx_data = 8'h00; h_rx_valid = 1'b0;
      h_irq_req = 1'b0;
      step(); step();
      check("rst_tx_valid", h_tx_valid, 0);
      check("rst_rx_ready", h_rx_ready, 0);
      check("rst_int", cpu_int, 0);
      check("rst_in_port", cpu_in_port, 8'h00);
      check("rst_overflow", out_overflow, 0);
      check("rst_halted", halted, 0);
      rst = 1'b1;
      step();
      check("rel_rx_ready", h_rx_ready, 1);

      // reset asserted with data queued in both directions
      cpu_out_we = 1'b1; cpu_out_port = 8'h77; h_rx_valid = 1'b1; h_rx_data = 8'h99;
      step();
      cpu_out_we = 1'b0; h_rx_valid = 1'b0;
      check("pre_tx_valid", h_tx_valid, 1);
      check("pre_in_port", cpu_in_port, 8'h99);
      #2 rst = 1'b0;
      #1;
      check("mid_tx_valid", h_tx_valid, 0);
      check("mid_in_avail", in_avail, 0);
      check("mid_in_port", cpu_in_port, 8'h00);
      check("mid_rx_ready", h_rx_ready, 0);
      step();
      rst = 1'b1;
      step(); step();
      check("post_rx_ready", h_rx_ready, 1);
      check("post_tx_valid", h_tx_valid, 0);
      check("post_int", cpu_int, 0);

      // OUT path
      cpu_out_we = 1'b1; cpu_out_port = 8'hA5;
      step();
      cpu_out_port = 8'h3C;
      step();
      cpu_out_we = 1'b0;
      check("out_valid", h_tx_valid, 1);
      check("out_head_a5", h_tx_data, 8'hA5);
      step();
      check("out_hold_a5", h_tx_data, 8'hA5);
      h_tx_ready = 1'b1;
      step();
      check("out_head_3c", h_tx_data, 8'h3C);
      check("out_valid_3c", h_tx_valid, 1);
      step();
      check("out_empty", h_tx_valid, 0);
      h_tx_ready = 1'b0;

      // fill to full, then push+pop when full, then a real overflow
      for (int i = 0; i < 8; i++) begin
         cpu_out_we = 1'b1; cpu_out_port = 8'(8'h10 + i);
         step();
      end
      check("full_no_ovf", out_overflow, 0);
      check("full_head", h_tx_data, 8'h10);
      cpu_out_port = 8'hEE; h_tx_ready = 1'b1;
      step();
      check("pushpop_no_ovf", out_overflow, 0);
      check("pushpop_head", h_tx_data, 8'h11);
      h_tx_ready = 1'b0; cpu_out_port = 8'hFF;
      step();
      cpu_out_we = 1'b0;
      check("ovf_set", out_overflow, 1);
      for (int i = 0; i < 8; i++) begin
         check("drain_data", h_tx_data, (i < 7) ? 32'(8'h11 + i) : 32'hEE);
         h_tx_ready = 1'b1;
         step();
      end
      check("drain_done", h_tx_valid, 0);
      check("ovf_sticky", out_overflow, 1);
      h_tx_ready = 1'b0;

      // IN path with interrupt
      h_rx_valid = 1'b1; h_rx_data = 8'h42;
      step();
      h_rx_valid = 1'b0;
      check("in_port_42", cpu_in_port, 8'h42);
      check("in_avail_42", in_avail, 1);
      count_int(8, n_int);
      check("int_width", n_int, 2);
      // irq edge during holdoff is held pending until the CPU consumes the byte
      h_irq_req = 1'b1;
      step();
      h_irq_req = 1'b0;
      step(); step();
      check("holdoff_quiet", cpu_int, 0);
      cpu_in_ack = 1'b1;
      step();
      cpu_in_ack = 1'b0;
      check("ack_in_avail", in_avail, 0);
      check("ack_in_port_hold", cpu_in_port, 8'h42);
      count_int(6, n_int);
      check("pending_int", n_int, 2);
      count_int(4, n_int);
      check("idle_quiet", n_int, 0);

      // back-to-back host bytes
      h_rx_valid = 1'b1; h_rx_data = 8'h11;
      step();
      h_rx_data = 8'h22;
      step();
      h_rx_valid = 1'b0;
      count_int(8, n_int);
      check("b2b_one_int", n_int, 2);
      check("b2b_head_11", cpu_in_port, 8'h11);
      cpu_in_ack = 1'b1;
      step();
      cpu_in_ack = 1'b0;
      check("b2b_head_22", cpu_in_port, 8'h22);
      check("b2b_avail", in_avail, 1);
      count_int(8, n_int);
      check("b2b_second_int", n_int, 2);
      cpu_in_ack = 1'b1;
      step();
      cpu_in_ack = 1'b0;
      check("b2b_drained", in_avail, 0);
      step(); step();

      // halt during PULSE
      cpu_out_we = 1'b1; cpu_out_port = 8'h5A;
      step();
      cpu_out_we = 1'b0;
      h_irq_req = 1'b1;
      step();
      check("halt_pulse_on", cpu_int, 1);
      cpu_hlt = 1'b1;
      step();
      check("halt_int_off", cpu_int, 0);
      check("halt_flag", halted, 1);
      check("halt_tx_valid", h_tx_valid, 1);
      check("halt_tx_data", h_tx_data, 8'h5A);
      h_tx_ready = 1'b1;
      step();
      h_tx_ready = 1'b0;
      check("halt_drained", h_tx_valid, 0);
      count_int(4, n_int);
      check("halt_quiet", n_int, 0);
      cpu_hlt = 1'b0;
      step();
      check("unhalt_flag", halted, 0);
      count_int(4, n_int);
      check("unhalt_no_pending", n_int, 0);
      h_irq_req = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got 0 exp 1");
      $fatal(1);
   end

endmodule
